pending_encoder: RTL and testbench
==================================

# pending_encoder

- Parametrised, registered priority encoder for N request lines.
- Request events are latched into a sticky pending vector.
- Pending requests are issued one at a time as an encoded index on a valid/ready output. Arbitration is either fixed-priority or round-robin.
- Sits between event sources (interrupt/status lines) and a single consumer; successor to the team's combinational 8-to-3 encoder with enable.

## Interface
Parameters:
- N, 8, number of request lines (N ≥ 2).
- W, derived, W = $clog2(N); index width, not overridable.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- EN  input  1  block enable. 0 = no capture, no issue, outputs hold.
- A  input  N  request lines, sampled each clk edge.
- rr  input  1  arbitration mode: 0 = fixed priority, highest index wins; 1 = round-robin.
- clr  input  1  synchronous clear of all pending requests and of the output slot.
- ready  input  1  consumer accepts Y this cycle.
- Y  output  W  encoded index of issued request (registered).
- valid  output  1  Y holds an unconsumed request (registered).
- pending  output  N  current sticky pending vector (registered).

## Operation
- **Capture:** at each edge with EN=1, pending ← pending | A. Sampled bits are sticky until issued.
- **Output slot:** Y/valid is a one-entry register.
- **Load condition:** load = EN & (!valid | ready).
  - On load with pending ≠ 0: the selected index idx goes to Y, valid ← 1, and pending[idx] is cleared.
  - On load with pending = 0: valid ← 0 and Y holds its last value.
- **Selection source:** selection uses the registered pending vector only; A presented in the same cycle is not a candidate.
- **Fixed mode:** idx is the highest set bit of pending.
- **Round-robin mode:**
  - ptr (W bits) records the last issued index.
  - Search proceeds from ptr+1 upward, wrapping modulo N; the first set bit wins.
  - ptr ← idx on every load that issues, in either mode.
- **Mode change:** rr may change at any time; it takes effect at the next load.
- **EN=0:** pending, Y, valid and ptr all hold. Asserting ready while valid=1 and EN=0 does not consume.
- **clr=1:** regardless of EN, at the next edge pending ← 0 and valid ← 0; ptr holds. clr has priority over capture and load.
- **Handshake:**
  - Transfer occurs on an edge where valid & ready & EN.
  - Y must stay stable while valid=1 and not transferred.
  - ready may be asserted while valid=0; there is no effect.

## Timing
- **Reset** (rst_n low, asynchronous): pending = 0, valid = 0, Y = 0, ptr = N-1, so the first round-robin search starts at bit 0. Reset deasserts synchronously to clk, driven externally.
- **Latency:** A[i] high at edge k sets pending[i] after edge k. If the slot is free or being consumed, Y = i and valid = 1 after edge k+1. Minimum latency is 2 edges from A to valid.
- **Throughput:** one issue per cycle while ready=1 and pending ≠ 0.
- **Capture vs. issue, same bit:** A[idx]=1 on the same edge that issues idx leaves pending[idx]=1 (set wins) and counts as a new event.
- **Repeated events:** re-asserting an already-pending bit is absorbed, not counted.
- **Round-robin wrap:** ptr = N-1 searches from bit 0. With pending having only bit ptr set, that bit is re-issued.
- **Reset mid-operation:** all state clears immediately, and any in-flight Y/valid is dropped.
- **Non-power-of-two N:** indices ≥ N never appear on Y, and the round-robin wrap is at N, not 2^W.

## Test plan
1. **Reset:** rst_n=0 with A=8'hFF, EN=1 -> pending=0, valid=0, Y=0 throughout; after release, first issue occurs 2 edges after capture.
2. **Fixed priority:** N=8, rr=0, ready=1, A=8'b00100101 for one cycle -> Y=5, 2, 0 with valid=1 on three consecutive cycles, then valid=0; pending walks 8'b00000101, 8'b00000001, 0.
3. **Round-robin:** rr=1, ready=1, A=8'hFF for one cycle after reset -> Y=0,1,2,...,7 on consecutive cycles. Then A=8'b10000001 -> Y=0 then 7.
4. **Backpressure:** ready=0, A=8'b00010000 -> valid=1, Y=4 held for 5 cycles. A=8'b00000010 during the stall -> pending=8'b00000010. Raise ready -> Y=1 the next cycle, then valid=0.
5. **Enable gating:** EN=0 with A=8'b00100000 and ready=1 while valid=1, Y=3 -> no capture (pending unchanged), Y=3/valid=1 hold. EN=1 -> transfer resumes.
6. **Clear and reset mid-stream:**
   - clr=1 with A=8'hFF, valid=1 -> next cycle pending=0, valid=0.
   - rst_n pulsed low mid-burst -> all outputs 0 asynchronously, and ptr restarts at N-1 (next round-robin issue from bit 0).

Source files
------------

// File: rtl/pending_encoder.sv
// Registered priority encoder: sticky capture of N request lines, issued one
// index at a time on a one-entry valid/ready slot, fixed-priority or round-robin.
module pending_encoder #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 EN,
    input  logic [N-1:0]         A,
    input  logic                 rr,
    input  logic                 clr,
    input  logic                 ready,
    output logic [$clog2(N)-1:0] Y,
    output logic                 valid,
    output logic [N-1:0]         pending
);

    localparam int W = $clog2(N);

    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] y_q, y_d;
    logic         valid_q, valid_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic [W-1:0] fix_idx;
    logic [W-1:0] rr_idx;
    logic         rr_found;
    logic [W-1:0] sel_idx;
    logic         has_req;
    logic         load;

    // Fixed priority: the last set bit seen while scanning upward is the highest.
    always_comb begin
        fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pending_q[i]) fix_idx = W'(i);
        end
    end

    // Round-robin: scan ptr+1 .. ptr+N, wrapping at N rather than 2^W.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            if (!rr_found && pending_q[j]) begin
                rr_found = 1'b1;
                rr_idx   = W'(j);
            end
        end
    end

    assign has_req = |pending_q;
    assign sel_idx = rr ? rr_idx : fix_idx;
    assign load    = EN & (~valid_q | ready);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        pending_d = pending_q;
        y_d       = y_q;
        valid_d   = valid_q;
        ptr_d     = ptr_q;
        if (clr) begin
            pending_d = '0;
            valid_d   = 1'b0;
        end else if (EN) begin
            if (load) begin
                if (has_req) begin
                    y_d                = sel_idx;
                    valid_d            = 1'b1;
                    ptr_d              = sel_idx;
                    pending_d[sel_idx] = 1'b0;
                end else begin
                    valid_d = 1'b0;
                end
            end
            // Capture after the issue-clear so a same-edge re-request survives.
            pending_d = pending_d | A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            y_q       <= '0;
            valid_q   <= 1'b0;
            ptr_q     <= W'(N - 1);
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            pending_q <= pending_d;
            y_q       <= y_d;
            valid_q   <= valid_d;
            ptr_q     <= ptr_d;
        end
    end

    assign Y       = y_q;
    assign valid   = valid_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_pending_encoder.sv
// Self-checking bench for pending_encoder: per-cycle vector table plus
// hand-written round-robin and reset sequences, with a transfer scoreboard.
module tb_pending_encoder;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b1;
    logic [N-1:0] a = '1;
    logic         rr = 1'b0;
    logic         clr = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] y;
    logic         valid;
    logic [N-1:0] pending;

    pending_encoder #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .EN     (en),
        .A      (a),
        .rr     (rr),
        .clr    (clr),
        .ready  (ready),
        .Y      (y),
        .valid  (valid),
        .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic [N-1:0] a;
        logic         rdy;
        logic         clr;
        logic [N-1:0] pend;
        logic         vld;
        logic [W-1:0] y;
        int           iss;   // index expected to be loaded into Y by this edge, -1 if none
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: scoreboard any transfer happening at this edge, then settle past it.
    task automatic step();
        logic [W-1:0] e;
        if (rst_n && en && valid && ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL xfer_unexpected: got Y=%0d, expected no transfer", y);
            end else begin
                e = exp_q.pop_front();
                check("xfer_y", 32'(y), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic e, input logic [N-1:0] av, input logic rd, input logic cl,
                       input logic [N-1:0] p, input logic v, input logic [W-1:0] yv, input int iss);
        vec_t t;
        t.en = e; t.a = av; t.rdy = rd; t.clr = cl;
        t.pend = p; t.vld = v; t.y = yv; t.iss = iss;
        vecs.push_back(t);
    endtask

    task automatic check_out(input string tag, input logic [N-1:0] p, input logic v, input logic [W-1:0] yv);
        check({tag, "_pending"}, 32'(pending), 32'(p));
        check({tag, "_valid"}, 32'(valid), 32'(v));
        check({tag, "_y"}, 32'(y), 32'(yv));
    endtask

    initial begin
        // Fixed priority 8'b00100101 -> 5, 2, 0
        add(1, 8'h25, 1, 0, 8'h25, 0, 0, -1);
        add(1, 8'h00, 1, 0, 8'h05, 1, 5,  5);
        add(1, 8'h00, 1, 0, 8'h01, 1, 2,  2);
        add(1, 8'h00, 1, 0, 8'h00, 1, 0,  0);
        add(1, 8'h00, 1, 0, 8'h00, 0, 0, -1);
        // Backpressure: Y=4 held five cycles, bit 1 captured during the stall
        add(1, 8'h10, 0, 0, 8'h10, 0, 0, -1);
        add(1, 8'h00, 0, 0, 8'h00, 1, 4,  4);
        add(1, 8'h02, 0, 0, 8'h02, 1, 4, -1);
        add(1, 8'h00, 0, 0, 8'h02, 1, 4, -1);
        add(1, 8'h00, 0, 0, 8'h02, 1, 4, -1);
        add(1, 8'h00, 0, 0, 8'h02, 1, 4, -1);
        add(1, 8'h00, 1, 0, 8'h00, 1, 1,  1);
        add(1, 8'h00, 1, 0, 8'h00, 0, 1, -1);
        // Enable gating: no capture, no consume while EN=0
        add(1, 8'h08, 0, 0, 8'h08, 0, 1, -1);
        add(1, 8'h00, 0, 0, 8'h00, 1, 3,  3);
        add(0, 8'h20, 1, 0, 8'h00, 1, 3, -1);
        add(0, 8'h20, 1, 0, 8'h00, 1, 3, -1);
        add(1, 8'h00, 1, 0, 8'h00, 0, 3, -1);
        // Same-bit capture on the issuing edge counts as a new event
        add(1, 8'h40, 1, 0, 8'h40, 0, 3, -1);
        add(1, 8'h40, 1, 0, 8'h40, 1, 6,  6);
        add(1, 8'h00, 1, 0, 8'h00, 1, 6,  6);
        add(1, 8'h00, 1, 0, 8'h00, 0, 6, -1);
        // Clear drops pending and the slot; also with EN=0
        add(1, 8'hFF, 0, 0, 8'hFF, 0, 6, -1);
        add(1, 8'h00, 0, 0, 8'h7F, 1, 7, -1);
        add(1, 8'hFF, 0, 1, 8'h00, 0, 7, -1);
        add(1, 8'h00, 0, 0, 8'h00, 0, 7, -1);
        add(1, 8'h03, 0, 0, 8'h03, 0, 7, -1);
        add(1, 8'h00, 0, 0, 8'h01, 1, 1, -1);
        add(0, 8'hFF, 1, 1, 8'h00, 0, 1, -1);
        add(1, 8'h00, 1, 0, 8'h00, 0, 1, -1);

        // Reset held with requests active
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("rst_hold", 8'h00, 1'b0, 3'd0);
        end
        rst_n = 1'b1; a = 8'h01; ready = 1'b1;
        step();
        check_out("rst_cap", 8'h01, 1'b0, 3'd0);
        a = 8'h00; exp_q.push_back(3'd0);
        step();
        check_out("rst_issue", 8'h00, 1'b1, 3'd0);
        step();
        check("rst_drain_valid", 32'(valid), 32'd0);

        // Table-driven vectors (fixed priority)
        foreach (vecs[i]) begin
            en = vecs[i].en; a = vecs[i].a; ready = vecs[i].rdy; clr = vecs[i].clr;
            if (vecs[i].iss >= 0) exp_q.push_back(W'(vecs[i].iss));
            step();
            check_out($sformatf("vec%0d", i), vecs[i].pend, vecs[i].vld, vecs[i].y);
        end
        clr = 1'b0; en = 1'b1; a = '0;

        // Round-robin from reset: 0..7, then 8'b10000001 -> 0 then 7
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; rr = 1'b1; ready = 1'b1; a = 8'hFF;
        step();
        check("rr_cap_pending", 32'(pending), 32'hFF);
        a = 8'h00;
        for (int k = 0; k < N; k++) exp_q.push_back(W'(k));
        for (int k = 0; k < N; k++) begin
            step();
            check($sformatf("rr_y%0d", k), 32'(y), 32'(k));
        end
        a = 8'h81; exp_q.push_back(3'd0); exp_q.push_back(3'd7);
        step();
        check("rr_drain_valid", 32'(valid), 32'd0);
        a = 8'h00;
        step();
        check_out("rr_81_first", 8'h80, 1'b1, 3'd0);
        step();
        check_out("rr_81_second", 8'h00, 1'b1, 3'd7);
        // Only bit ptr set: it is re-issued after a full wrap
        a = 8'h80;
        step();
        check("rr_wrap_valid", 32'(valid), 32'd0);
        a = 8'h00; exp_q.push_back(3'd7);
        step();
        check_out("rr_wrap_reissue", 8'h00, 1'b1, 3'd7);
        step();
        check("rr_wrap_drain", 32'(valid), 32'd0);

        // Asynchronous reset mid-burst, ptr restarts at N-1
        a = 8'hFF;
        step();
        a = 8'h00; exp_q.push_back(3'd0);
        step();
        step();
        check("mid_before_y", 32'(y), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_out("mid_async", 8'h00, 1'b0, 3'd0);
        step();
        rst_n = 1'b1; a = 8'h81; exp_q.push_back(3'd0); exp_q.push_back(3'd7);
        step();
        a = 8'h00;
        step();
        check_out("mid_rr_first", 8'h80, 1'b1, 3'd0);
        step();
        check_out("mid_rr_second", 8'h00, 1'b1, 3'd7);
        step();
        check("mid_drain", 32'(valid), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
